mult_rr_scheduler: RTL and testbench
====================================

# mult_rr_scheduler

Round-robin scheduler that shares one pipelined multiplier (valid-in/valid-out, fixed but unknown latency) among NREQ requesters. It accepts at most one operand pair per cycle and drives the multiplier from registered outputs. A tag FIFO records which requester owns each in-flight product, so results return to the correct requester in issue order. It sits between the requesting engines and the multiplier instance.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH
- NREQ, 4, number of requesters (2..8)
- TAG_DEPTH, 8, tag FIFO depth; power of 2; at least multiplier latency + 1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sched_en  in  1  when 0, no new grants; in-flight work still completes
- req_valid  in  NREQ  requester i has an operand pair
- req_a, req_b  in  NREQ*WIDTH  packed operands; requester i uses bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot or zero; combinational grant, transfer when valid & ready
- mul_a, mul_b  out  WIDTH  registered operands to multiplier
- mul_valid_in  out  1  registered, one-cycle pulse per issued pair
- mul_product  in  2*WIDTH  multiplier result
- mul_valid_out  in  1  result valid this cycle
- rsp_valid  out  1  registered response pulse; no backpressure
- rsp_id  out  $clog2(NREQ)  owning requester
- rsp_product  out  2*WIDTH  registered copy of mul_product
- tag_err  out  1  sticky: mul_valid_out seen with empty tag FIFO

## Operation
- Arbitration: round-robin pointer ptr, reset value 0. Search order is ptr, ptr+1, … mod NREQ. The first requester with req_valid=1 is granted.
- A grant (req_ready[g]=1) requires all of: sched_en=1, tag FIFO count < TAG_DEPTH, not in reset. A full FIFO blocks grants even if a pop happens in the same cycle.
- On transfer: register mul_a/mul_b from requester g and set mul_valid_in=1 next cycle. Push g into the tag FIFO. Set ptr=(g+1) mod NREQ.
- If no transfer: mul_valid_in=0 next cycle. mul_a/mul_b hold their last values. ptr is unchanged.
- On mul_valid_out=1 with FIFO non-empty: pop the head. Next cycle rsp_valid=1, rsp_id=head, rsp_product=mul_product.
- On mul_valid_out=1 with FIFO empty: no pop, no response, tag_err set until rst.
- Push and pop in the same cycle leave count unchanged. Wrap-around of the FIFO pointers is modulo TAG_DEPTH.
- Reset mid-operation: FIFO is emptied, ptr=0, tag_err=0. Results from the multiplier that belong to pre-reset requests are then treated as underflow. The system must reset the multiplier together with this block.

## Timing
- Reset values: req_ready=0, mul_a=0, mul_b=0, mul_valid_in=0, rsp_valid=0, rsp_id=0, rsp_product=0, tag_err=0.
- Accept in cycle T gives mul_valid_in in T+1. If the multiplier latency is L, mul_valid_out arrives in T+1+L and rsp_valid in T+2+L.
- Sustained throughput is one issue per cycle while the FIFO is not full.
- Lowering sched_en takes effect in the same cycle: req_ready goes to 0 combinationally.
- req_ready depends only on registered state, req_valid and sched_en. It must not depend on mul_valid_out.

## Configuration
- MULT_SCHED_PERF_EN defined: adds outputs issue_cnt (32-bit, counts transfers) and stall_cnt (32-bit, counts cycles with any req_valid but no grant). Both reset to 0 and wrap at 2^32.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single request: requester 2 sends a=255, b=255 with a 3-stage multiplier. req_ready[2] is high in cycle T, mul_valid_in in T+1, rsp_valid in T+5 with rsp_id=2 and rsp_product=65025.
- All four requesters hold valid continuously from reset. Grants go 0,1,2,3,0,1… one per cycle, and responses return with matching ids and correct products.
- Multiplier stalled (mul_valid_out never asserted) with TAG_DEPTH=8. Exactly 8 grants occur, then req_ready stays 0. The first mul_valid_out reopens exactly one grant in the following cycle.
- sched_en dropped with 3 requests in flight. No new grants occur, and all 3 responses still arrive in issue order.
- A spurious mul_valid_out with the FIFO empty sets tag_err=1 with no rsp_valid. tag_err stays 1 until rst; rst clears it and returns ptr to 0.
- With MULT_SCHED_PERF_EN: 10 transfers and 4 blocked cycles give issue_cnt=10 and stall_cnt=4.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler
//
// Shares one pipelined multiplier between NREQ requesters. A round-robin
// arbiter grants at most one operand pair per cycle. The operands go to the
// multiplier from registers. A tag FIFO records the owner of every product
// that is in flight, so each result returns to the requester that issued it,
// in issue order.
//
// Parameters
//   WIDTH      operand width (product is 2*WIDTH)
//   NREQ       number of requesters (2..8)
//   TAG_DEPTH  tag FIFO depth, power of 2, at least multiplier latency + 1
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   sched_en       0 blocks new grants; in-flight work still completes
//   req_valid      per-requester operand-pair valid
//   req_a, req_b   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready      combinational one-hot (or zero) grant
//   mul_a, mul_b   registered operands to the multiplier
//   mul_valid_in   registered issue pulse to the multiplier
//   mul_product    multiplier result
//   mul_valid_out  multiplier result valid
//   rsp_valid      registered response pulse (no backpressure)
//   rsp_id         requester that owns the response
//   rsp_product    registered copy of mul_product
//   tag_err        sticky: a result arrived while the tag FIFO was empty
//
// Optional feature (macro MULT_SCHED_PERF_EN)
//   issue_cnt      32-bit count of transfers
//   stall_cnt      32-bit count of cycles with a request but no grant
// -----------------------------------------------------------------------------
module mult_rr_scheduler #(
    parameter int WIDTH     = 16,
    parameter int NREQ      = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sched_en,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_a,
    input  logic [NREQ*WIDTH-1:0]      req_b,
    output logic [NREQ-1:0]            req_ready,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    output logic                       mul_valid_in,
    input  logic [2*WIDTH-1:0]         mul_product,
    input  logic                       mul_valid_out,
    output logic                       rsp_valid,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [2*WIDTH-1:0]         rsp_product,
    output logic                       tag_err
`ifdef MULT_SCHED_PERF_EN
    ,
    output logic [31:0]                issue_cnt,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(TAG_DEPTH);
    localparam int CW  = AW + 1;

    // Adds two requester indices modulo NREQ (NREQ need not be a power of 2).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input logic [IDW-1:0] off);
        logic [IDW:0] sum_v;
        sum_v = {1'b0, base} + {1'b0, off};
        if (sum_v >= (IDW+1)'(NREQ)) begin
            sum_v = sum_v - (IDW+1)'(NREQ);
        end else begin
            sum_v = sum_v;
        end
        return sum_v[IDW-1:0];
    endfunction

    // Arbitration and issue state
    logic [IDW-1:0]        ptr_r;
    logic [IDW-1:0]        idx_s;
    logic [IDW-1:0]        gidx_s;
    logic                  found_s;
    logic                  can_grant_s;
    logic                  transfer_s;
    logic [NREQ-1:0]       grant_s;
    logic [WIDTH-1:0]      a_sel_s;
    logic [WIDTH-1:0]      b_sel_s;
    logic [WIDTH-1:0]      mul_a_r;
    logic [WIDTH-1:0]      mul_b_r;
    logic                  mul_valid_in_r;

    // Tag FIFO state
    logic [IDW-1:0]        tag_mem_r [TAG_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         cnt_r;
    logic                  fifo_full_s;
    logic                  pop_s;
    logic                  underflow_s;

    // Response state
    logic                  rsp_valid_r;
    logic [IDW-1:0]        rsp_id_r;
    logic [2*WIDTH-1:0]    rsp_product_r;
    logic                  tag_err_r;

    // A full FIFO blocks grants even when a pop happens in the same cycle, so
    // req_ready never depends on mul_valid_out.
    assign fifo_full_s = (cnt_r == CW'(TAG_DEPTH));
    assign can_grant_s = sched_en & ~fifo_full_s & ~rst;
    assign pop_s       = mul_valid_out & (cnt_r != '0);
    assign underflow_s = mul_valid_out & (cnt_r == '0);

    // Round-robin search: first valid requester starting at ptr_r.
    always_comb begin
        found_s = 1'b0;
        gidx_s  = '0;
        idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = wrap_idx(ptr_r, IDW'(k));
            if (!found_s && req_valid[idx_s]) begin
                found_s = 1'b1;
                gidx_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant vector and selected operands.
    always_comb begin
        grant_s = '0;
        if (found_s && can_grant_s) begin
            grant_s[gidx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign transfer_s = found_s & can_grant_s;
    assign a_sel_s    = req_a[gidx_s*WIDTH +: WIDTH];
    assign b_sel_s    = req_b[gidx_s*WIDTH +: WIDTH];

    // Issue registers: operands, issue pulse and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a_r        <= '0;
            mul_b_r        <= '0;
            mul_valid_in_r <= 1'b0;
            ptr_r          <= '0;
        end else if (transfer_s) begin
            mul_a_r        <= a_sel_s;
            mul_b_r        <= b_sel_s;
            mul_valid_in_r <= 1'b1;
            ptr_r          <= wrap_idx(gidx_s, IDW'(1));
        end else begin
            mul_valid_in_r <= 1'b0;
        end
    end

    // Tag storage; contents are only meaningful between the read and write pointers.
    always_ff @(posedge clk) begin
        if (transfer_s) begin
            tag_mem_r[wr_ptr_r] <= gidx_s;
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (transfer_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({transfer_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Response registers and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= '0;
            rsp_product_r <= '0;
            tag_err_r     <= 1'b0;
        end else begin
            rsp_valid_r <= pop_s;
            if (pop_s) begin
                rsp_id_r      <= tag_mem_r[rd_ptr_r];
                rsp_product_r <= mul_product;
            end
            if (underflow_s) begin
                tag_err_r <= 1'b1;
            end
        end
    end

`ifdef MULT_SCHED_PERF_EN
    logic [31:0] issue_cnt_r;
    logic [31:0] stall_cnt_r;

    // Performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_r <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (transfer_s) begin
                issue_cnt_r <= issue_cnt_r + 32'd1;
            end
            if ((|req_valid) && !transfer_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_r;
    assign stall_cnt = stall_cnt_r;
`endif

    assign req_ready    = grant_s;
    assign mul_a        = mul_a_r;
    assign mul_b        = mul_b_r;
    assign mul_valid_in = mul_valid_in_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_id       = rsp_id_r;
    assign rsp_product  = rsp_product_r;
    assign tag_err      = tag_err_r;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: table-driven arbitration vectors,
// directed multi-cycle sequences and randomized traffic against a queue-based
// reference model. The multiplier is modelled as an in-order queue of products
// with a 3-cycle latency and an optional release gate to emulate stalls.
module tb_mult_rr_scheduler;

    localparam int WIDTH     = 16;
    localparam int NREQ      = 4;
    localparam int TAG_DEPTH = 8;
    localparam int LAT       = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sched_en;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic [NREQ-1:0]         req_ready;
    logic [WIDTH-1:0]        mul_a;
    logic [WIDTH-1:0]        mul_b;
    logic                    mul_valid_in;
    logic [2*WIDTH-1:0]      mul_product;
    logic                    mul_valid_out;
    logic                    rsp_valid;
    logic [1:0]              rsp_id;
    logic [2*WIDTH-1:0]      rsp_product;
    logic                    tag_err;
`ifdef MULT_SCHED_PERF_EN
    logic [31:0]             issue_cnt;
    logic [31:0]             stall_cnt;
`endif

    mult_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid_in(mul_valid_in),
        .mul_product(mul_product), .mul_valid_out(mul_valid_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .tag_err(tag_err)
`ifdef MULT_SCHED_PERF_EN
        , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: in-order products with the cycle they become available.
    typedef struct {
        logic [31:0] p;
        int          rdy;
    } mq_t;
    mq_t mq[$];

    // Reference model of the scheduler.
    int          tq_id[$];
    logic [31:0] tq_prod[$];
    int          ptr_m;
    logic        e_mvi, e_rv, e_err;
    logic [15:0] e_a, e_b;
    int          e_id;
    logic [31:0] e_prod;
    logic [31:0] e_issue, e_stall;

    logic        gate;
    logic        spur;
    int          cyc;
    logic [3:0]  obs_ready;
    int          n_vec;
    int          n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive multiplier output, check grant, update model,
    // cross the edge, check registered outputs, capture issued operands.
    task automatic tick();
        logic [3:0]  exp_rdy;
        logic        mvo;
        logic [31:0] prod;
        logic [31:0] pa;
        logic        was_empty;
        int          g;
        if (spur) begin
            mvo  = 1'b1;
            prod = $urandom;
        end else if (!rst && mq.size() > 0 && mq[0].rdy <= cyc && gate) begin
            mvo  = 1'b1;
            prod = mq[0].p;
        end else begin
            mvo  = 1'b0;
            prod = $urandom;
        end
        mul_valid_out = mvo;
        mul_product   = prod;
        #1;
        exp_rdy = 4'b0000;
        g = -1;
        if (!rst && sched_en && tq_id.size() < TAG_DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr_m + k) % NREQ;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs_ready = req_ready;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (rst) begin
            tq_id.delete(); tq_prod.delete(); mq.delete();
            ptr_m = 0; e_mvi = 0; e_a = 0; e_b = 0; e_rv = 0; e_id = 0;
            e_prod = 0; e_err = 0; e_issue = 0; e_stall = 0;
        end else begin
            was_empty = (tq_id.size() == 0);
            if (mvo && !was_empty) begin
                e_rv   = 1'b1;
                e_id   = tq_id.pop_front();
                e_prod = tq_prod.pop_front();
            end else begin
                e_rv = 1'b0;
                if (mvo) e_err = 1'b1;
            end
            if (mvo && !spur) mq.delete(0);
            if (g >= 0) begin
                pa = 32'(req_a[g*WIDTH +: WIDTH]) * 32'(req_b[g*WIDTH +: WIDTH]);
                tq_id.push_back(g);
                tq_prod.push_back(pa);
                e_mvi = 1'b1;
                e_a   = req_a[g*WIDTH +: WIDTH];
                e_b   = req_b[g*WIDTH +: WIDTH];
                ptr_m = (g + 1) % NREQ;
                e_issue = e_issue + 32'd1;
            end else begin
                e_mvi = 1'b0;
                if (|req_valid) e_stall = e_stall + 32'd1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("mul_valid_in", 64'(mul_valid_in), 64'(e_mvi));
        check("mul_a", 64'(mul_a), 64'(e_a));
        check("mul_b", 64'(mul_b), 64'(e_b));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        check("tag_err", 64'(tag_err), 64'(e_err));
        if (e_rv) begin
            check("rsp_id", 64'(rsp_id), 64'(e_id));
            check("rsp_product", 64'(rsp_product), 64'(e_prod));
        end
`ifdef MULT_SCHED_PERF_EN
        check("issue_cnt", 64'(issue_cnt), 64'(e_issue));
        check("stall_cnt", 64'(stall_cnt), 64'(e_stall));
`endif
        if (mul_valid_in) begin
            mq_t m;
            m.p   = 32'(mul_a) * 32'(mul_b);
            m.rdy = cyc + LAT;
            mq.push_back(m);
        end
    endtask

    task automatic rand_ops();
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 4'b1111; sched_en = 1'b1; gate = 1'b1; spur = 1'b0;
        tick();
        tick();
        rst = 1'b0; req_valid = 4'b0000;
    endtask

    typedef struct {
        logic [3:0] rv;
        logic       en;
        logic [3:0] exp_rdy;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int t0, ngr, nrsp;
        logic found;
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b1; sched_en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        gate = 1'b1; spur = 1'b0; mul_valid_out = 1'b0; mul_product = '0;

        // Arbitration sequence from reset (ptr starts at 0).
        tbl[0] = '{4'b0000, 1'b1, 4'b0000};
        tbl[1] = '{4'b0100, 1'b1, 4'b0100};
        tbl[2] = '{4'b1111, 1'b1, 4'b1000};
        tbl[3] = '{4'b1111, 1'b1, 4'b0001};
        tbl[4] = '{4'b0001, 1'b1, 4'b0001};
        tbl[5] = '{4'b1111, 1'b0, 4'b0000};
        tbl[6] = '{4'b0110, 1'b1, 4'b0010};
        tbl[7] = '{4'b0110, 1'b1, 4'b0100};
        tbl[8] = '{4'b0011, 1'b1, 4'b0001};
        tbl[9] = '{4'b1000, 1'b1, 4'b1000};

        // Reset state (grants blocked while rst is high even with all requests).
        do_reset();
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_rsp_product", 64'(rsp_product), 64'd0);

        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].rv; sched_en = tbl[i].en; rand_ops();
            tick();
            check("tbl_grant", 64'(obs_ready), 64'(tbl[i].exp_rdy));
        end
        req_valid = '0; sched_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Single request from requester 2: 255*255 with a 3-cycle multiplier.
        do_reset();
        req_a = '0; req_b = '0;
        req_a[2*WIDTH +: WIDTH] = 16'd255;
        req_b[2*WIDTH +: WIDTH] = 16'd255;
        req_valid = 4'b0100;
        t0 = cyc;
        tick();
        check("single_grant", 64'(obs_ready), 64'(4'b0100));
        check("single_issue", 64'(mul_valid_in), 64'd1);
        req_valid = '0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (rsp_valid) begin
                found = 1'b1;
                check("single_latency", 64'(cyc), 64'(t0 + 5));
                check("single_id", 64'(rsp_id), 64'd2);
                check("single_product", 64'(rsp_product), 64'd65025);
            end
        end
        if (!found) check("single_timeout", 64'd0, 64'd1);

        // All four requesters valid continuously from reset.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 24; k++) begin
            rand_ops();
            tick();
            check("rr_order", 64'(obs_ready), 64'(4'b0001 << (k % 4)));
        end
        req_valid = '0;
        for (int k = 0; k < 10; k++) tick();

        // Stalled multiplier: exactly TAG_DEPTH grants, then one per pop.
        do_reset();
        gate = 1'b0; req_valid = 4'b1111; ngr = 0;
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            tick();
            if (obs_ready != 4'b0000) ngr++;
        end
        check("stall_grants", 64'(ngr), 64'(TAG_DEPTH));
        gate = 1'b1;
        tick();
        check("full_pop_same_cycle", 64'(obs_ready), 64'd0);
        gate = 1'b0;
        tick();
        check("reopen_one", 64'($countones(obs_ready)), 64'd1);
        tick();
        check("closed_again", 64'(obs_ready), 64'd0);
        gate = 1'b1; req_valid = '0;
        for (int k = 0; k < 20; k++) tick();
        check("stall_drained", 64'(tq_id.size()), 64'd0);

        // sched_en dropped with three requests in flight.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            tick();
        end
        sched_en = 1'b0; nrsp = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("en_low_no_grant", 64'(obs_ready), 64'd0);
            if (rsp_valid) begin
                check("en_low_order", 64'(rsp_id), 64'(nrsp));
                nrsp++;
            end
        end
        check("en_low_rsp_count", 64'(nrsp), 64'd3);

        // Spurious result with empty FIFO: sticky tag_err, cleared by reset.
        req_valid = '0;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_no_rsp", 64'(rsp_valid), 64'd0);
        check("spur_err", 64'(tag_err), 64'd1);
        for (int k = 0; k < 3; k++) tick();
        check("err_sticky", 64'(tag_err), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_cleared", 64'(tag_err), 64'd0);
        sched_en = 1'b1; req_valid = 4'b1111;
        tick();
        check("ptr_after_reset", 64'(obs_ready), 64'(4'b0001));
        req_valid = '0;
        for (int k = 0; k < 10; k++) tick();

`ifdef MULT_SCHED_PERF_EN
        // 10 transfers followed by 4 blocked cycles.
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            tick();
        end
        sched_en = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("perf_issue", 64'(issue_cnt), 64'd10);
        check("perf_stall", 64'(stall_cnt), 64'd4);
        req_valid = '0; sched_en = 1'b1;
        for (int k = 0; k < 10; k++) tick();
`endif

        // Randomized traffic with varying stall pressure and occasional reset.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if (k % 100 == 0) gate = 1'b1;
            rst       = ($urandom_range(299) == 0);
            req_valid = 4'($urandom);
            sched_en  = ($urandom_range(9) != 0);
            if (k % 200 >= 100) gate = ($urandom_range(3) == 0);
            else                gate = ($urandom_range(3) != 0);
            rand_ops();
            tick();
        end
        rst = 1'b0; req_valid = '0; gate = 1'b1; sched_en = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        check("final_drained", 64'(tq_id.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
